// File: rtl/loop_test_sequencer.sv
// loop_test_sequencer
//   Automates loop-interface test sweeps. For each sweep it walks the pattern
//   number 0..PATTERN_CNT-1 and pulses o_loop_enable once per pattern. Each
//   run is supervised by a watchdog. Pass/timeout counts and min/max cycle
//   statistics are accumulated for PC readout.
//
// Handshake with the loop interface: o_loop_enable is a level request. The
// loop interface answers with i_loop_run (started) and then i_loop_done
// (finished, with i_loop_cycle valid in the same cycle). The sequencer drops
// o_loop_enable and waits in GAP until both status lines return low.
//
// Ports
//   i_clk, i_arst_n            clock, asynchronous active-low reset
//   i_start, i_abort           control pulses from the register bank
//   i_repeat[15:0]             sweep count (0 behaves as 1)
//   o_busy, o_done, o_error    sequence status (done/error are sticky)
//   o_loop_enable              run request to the loop interface
//   o_pattern_num[2:0]         pattern number to the loop interface
//   i_loop_run, i_loop_done    loop interface status
//   i_loop_cycle[15:0]         cycle count of the current run
//   o_pass_cnt, o_timeout_cnt  saturating run counters
//   o_cycle_min, o_cycle_max   cycle statistics over passed runs
module loop_test_sequencer #(
  parameter int PATTERN_CNT    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_repeat,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_loop_enable,
  output logic [2:0]  o_pattern_num,
  input  logic        i_loop_run,
  input  logic        i_loop_done,
  input  logic [15:0] i_loop_cycle,
  output logic [15:0] o_pass_cnt,
  output logic [15:0] o_timeout_cnt,
  output logic [15:0] o_cycle_min,
  output logic [15:0] o_cycle_max
);

  localparam logic [2:0]  LAST_PAT = 3'(PATTERN_CNT - 1);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_GAP, S_NEXT} state_t;

  state_t      r_state, w_next;
  logic        r_busy, r_done, r_error, r_enable;
  logic [2:0]  r_pattern;
  logic [15:0] r_pass, r_tmo, r_min, r_max;
  logic [15:0] r_repeat, r_sweep, r_wd;
  logic        r_gap_cnt;     // 1 once the first GAP cycle has elapsed
  logic        r_abort_pend;

  logic        w_accept, w_pass_ev, w_tmo_ev, w_finish;
  logic        w_pat_adv, w_sweep_adv, w_abort_set, w_wd_hit;
  logic [16:0] w_sweep_inc;

  assign w_wd_hit    = (r_wd == WD_LIMIT);
  assign w_sweep_inc = {1'b0, r_sweep} + 17'd1;

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_pass_ev   = 1'b0;
    w_tmo_ev    = 1'b0;
    w_finish    = 1'b0;
    w_pat_adv   = 1'b0;
    w_sweep_adv = 1'b0;
    w_abort_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_accept = 1'b1;
          w_next   = S_ARM;
        end
      end
      S_ARM: begin
        if (i_abort) begin
          w_abort_set = 1'b1;
          w_next      = S_GAP;
        end else if (w_wd_hit) begin
          w_tmo_ev = 1'b1;
          w_next   = S_GAP;
        end else if (i_loop_run) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // done is checked before the watchdog so a coincident done passes
        if (i_abort) begin
          w_abort_set = 1'b1;
          w_next      = S_GAP;
        end else if (i_loop_done) begin
          w_pass_ev = 1'b1;
          w_next    = S_GAP;
        end else if (w_wd_hit) begin
          w_tmo_ev = 1'b1;
          w_next   = S_GAP;
        end
      end
      S_GAP: begin
        w_abort_set = i_abort;
        if (r_gap_cnt && !i_loop_run && !i_loop_done)
          w_next = (r_abort_pend || i_abort) ? S_IDLE : S_NEXT;
      end
      S_NEXT: begin
        if (i_abort) begin
          w_abort_set = 1'b1;
          w_next      = S_GAP;
        end else if (r_pattern < LAST_PAT) begin
          w_pat_adv = 1'b1;
          w_next    = S_ARM;
        end else begin
          w_sweep_adv = 1'b1;
          if (w_sweep_inc == {1'b0, r_repeat}) begin
            w_finish = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_next = S_ARM;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_enable     <= 1'b0;
      r_pattern    <= 3'd0;
      r_pass       <= 16'd0;
      r_tmo        <= 16'd0;
      r_min        <= 16'hFFFF;
      r_max        <= 16'd0;
      r_repeat     <= 16'd1;
      r_sweep      <= 16'd0;
      r_wd         <= 16'd0;
      r_gap_cnt    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != S_IDLE);
      r_enable  <= (w_next == S_ARM) || (w_next == S_RUN);
      r_gap_cnt <= (r_state == S_GAP);
      // Watchdog is zero in the first ARM cycle and counts through ARM and RUN.
      r_wd      <= ((r_state == S_ARM) || (r_state == S_RUN)) ? r_wd + 16'd1 : 16'd0;

      if (w_next == S_IDLE)  r_abort_pend <= 1'b0;
      else if (w_abort_set)  r_abort_pend <= 1'b1;

      if (w_accept) begin
        r_repeat  <= (i_repeat == 16'd0) ? 16'd1 : i_repeat;
        r_pass    <= 16'd0;
        r_tmo     <= 16'd0;
        r_done    <= 1'b0;
        r_error   <= 1'b0;
        r_min     <= 16'hFFFF;
        r_max     <= 16'd0;
        r_pattern <= 3'd0;
        r_sweep   <= 16'd0;
      end

      if (w_pass_ev) begin
        if (r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
        if (i_loop_cycle < r_min) r_min <= i_loop_cycle;
        if (i_loop_cycle > r_max) r_max <= i_loop_cycle;
      end

      if (w_tmo_ev) begin
        if (r_tmo != 16'hFFFF) r_tmo <= r_tmo + 16'd1;
        r_error <= 1'b1;
      end

      if (w_pat_adv) r_pattern <= r_pattern + 3'd1;
      if (w_sweep_adv) begin
        r_pattern <= 3'd0;
        r_sweep   <= w_sweep_inc[15:0];
      end
      if (w_finish) r_done <= 1'b1;
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_loop_enable = r_enable;
  assign o_pattern_num = r_pattern;
  assign o_pass_cnt    = r_pass;
  assign o_timeout_cnt = r_tmo;
  assign o_cycle_min   = r_min;
  assign o_cycle_max   = r_max;

endmodule

// File: tb/tb_loop_test_sequencer.sv
// Testbench for loop_test_sequencer (PATTERN_CNT=3, TIMEOUT_CYCLES=50).
// A loop-interface responder answers each enable; the expected pattern order
// is queued before each sequence and popped as each run starts.
module tb_loop_test_sequencer;

  localparam int PCNT = 3;
  localparam int TMO  = 50;

  logic        clk, rst_n;
  logic        i_start, i_abort;
  logic [15:0] i_repeat;
  logic        busy, done, error, loop_en;
  logic [2:0]  pat;
  logic        loop_run, loop_done;
  logic [15:0] loop_cycle;
  logic [15:0] pass_cnt, tmo_cnt, cmin, cmax;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  int         done_at;
  logic [7:0] hang_mask;
  int         run_cnt;

  loop_test_sequencer #(.PATTERN_CNT(PCNT), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_repeat(i_repeat), .o_busy(busy), .o_done(done), .o_error(error),
    .o_loop_enable(loop_en), .o_pattern_num(pat), .i_loop_run(loop_run),
    .i_loop_done(loop_done), .i_loop_cycle(loop_cycle), .o_pass_cnt(pass_cnt),
    .o_timeout_cnt(tmo_cnt), .o_cycle_min(cmin), .o_cycle_max(cmax)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loop-interface responder, updated on the falling edge.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst_n) begin
      loop_run = 1'b0; loop_done = 1'b0; loop_cycle = 16'd0; run_cnt = 0;
    end else if (loop_en) begin
      if (run_cnt == 0) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("pattern", {29'd0, pat}, {29'd0, e});
        end
      end
      loop_run = 1'b1;
      run_cnt++;
      if (run_cnt == done_at && !hang_mask[pat]) begin
        loop_done  = 1'b1;
        loop_cycle = 16'(100 + 10 * int'(pat));
      end
    end else begin
      if (run_cnt != 0 && hang_mask[pat]) check("timeout_len", run_cnt, TMO);
      loop_run = 1'b0; loop_done = 1'b0; run_cnt = 0;
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [15:0] rep);
    @(negedge clk);
    i_repeat = rep;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  task automatic push_sweeps(input int n);
    for (int s = 0; s < n; s++)
      for (int p = 0; p < PCNT; p++) exp_q.push_back(3'(p));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", {31'd0, (n < 2000)}, 32'd1);
  endtask

  task automatic check_stats(input string tag, input int p, input int t,
                             input int mn, input int mx);
    check({tag, "_pass"}, pass_cnt, p);
    check({tag, "_tmo"},  tmo_cnt, t);
    check({tag, "_min"},  cmin, mn);
    check({tag, "_max"},  cmax, mx);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_repeat = 16'd0;
    done_at = 20; hang_mask = 8'h00;
    #23;
    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_en", loop_en, 0);
    check("rst_pat", pat, 0);
    check_stats("rst", 0, 0, 16'hFFFF, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // two sweeps, all pass
    push_sweeps(2);
    pulse_start(16'd2);
    check("t1_busy", busy, 1);
    wait_idle();
    check_stats("t1", 6, 0, 100, 120);
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_busy_end", busy, 0);
    check("t1_q", exp_q.size(), 0);

    // pattern 1 never completes -> watchdog
    hang_mask = 8'b0000_0010;
    push_sweeps(2);
    pulse_start(16'd2);
    wait_idle();
    check_stats("t2", 4, 2, 100, 120);
    check("t2_error", error, 1);
    check("t2_done", done, 1);
    check("t2_q", exp_q.size(), 0);
    hang_mask = 8'h00;

    // abort in the 5th RUN cycle of pattern 2
    push_sweeps(1);
    pulse_start(16'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(loop_en && pat == 3'd2) && n < 500);
    check("t3_reach", {31'd0, (n < 500)}, 32'd1);
    repeat (5) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("t3_en_drop", loop_en, 0);
    wait_idle();
    check("t3_done", done, 0);
    check("t3_busy", busy, 0);
    check("t3_pat_hold", pat, 2);
    check_stats("t3", 2, 0, 100, 110);
    check("t3_q", exp_q.size(), 0);

    // repeat=0 behaves as one sweep
    push_sweeps(1);
    pulse_start(16'd0);
    wait_idle();
    check("t4_pass", pass_cnt, 3);
    check("t4_done", done, 1);
    check("t4_q", exp_q.size(), 0);

    // start while busy is ignored
    push_sweeps(1);
    pulse_start(16'd1);
    n = 0;
    while (pass_cnt != 16'd1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    pulse_start(16'd5);
    check("t5_busy", busy, 1);
    check("t5_no_clear", pass_cnt, 1);
    wait_idle();
    check("t5_pass", pass_cnt, 3);
    check("t5_q", exp_q.size(), 0);

    // start together with abort stays idle
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1; i_repeat = 16'd1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_en", loop_en, 0);
    check("t6_done_kept", done, 1);
    check("t6_pass_kept", pass_cnt, 3);

    // done coincident with the watchdog limit -> pass
    done_at = TMO;
    push_sweeps(1);
    pulse_start(16'd1);
    wait_idle();
    check_stats("t7", 3, 0, 100, 120);
    check("t7_error", error, 0);
    // one cycle later -> timeout
    done_at = TMO + 1;
    push_sweeps(1);
    pulse_start(16'd1);
    wait_idle();
    check_stats("t8", 0, 3, 16'hFFFF, 0);
    check("t8_error", error, 1);
    check("t8_q", exp_q.size(), 0);

    // async reset during RUN of pattern 1
    done_at = 20;
    push_sweeps(1);
    pulse_start(16'd1);
    n = 0;
    while (!(loop_run && pat == 3'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t9_en", loop_en, 0);
    check("t9_busy", busy, 0);
    check("t9_pat", pat, 0);
    check("t9_error", error, 0);
    check_stats("t9", 0, 0, 16'hFFFF, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
